// File: rtl/march_lr_bist.sv
// March LR MBIST controller for a single-port SRAM with async read, one op per clock.
// Define MARCH_LR_CKBD_EN to append a second pass with checkerboard backgrounds.
module march_lr_bist #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_in,
    input  logic [DATA_W-1:0] dat_in,
    output logic [DATA_W-1:0] dat_out,
    output logic [ADDR_W-1:0] addr_out,
    output logic              w_en_out,
    output logic              rst_done,
    output logic              fail,
    output logic [ADDR_W-1:0] fail_addr
);

    typedef enum logic [2:0] {
        S_IDLE, S_M0, S_M1, S_M2, S_M3, S_M4, S_M5, S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] A_MAX = '1;

    function automatic logic [DATA_W-1:0] ckbd_pat();
        logic [DATA_W-1:0] p;
        for (int i = 0; i < DATA_W; i++) p[i] = ((i % 2) == 0);
        return p;
    endfunction

    localparam logic [DATA_W-1:0] CKBD0 = ckbd_pat();

    state_t            state_q;
    logic [2:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic              fail_q;
    logic [ADDR_W-1:0] fail_addr_q;

`ifdef MARCH_LR_CKBD_EN
    logic ckbd_q;
`else
    logic ckbd_q;
    assign ckbd_q = 1'b0;
`endif

    logic              op_wr;
    logic              op_one;
    logic              op_last;
    logic              active;
    logic              elem_end;
    logic [DATA_W-1:0] bg;

    // Op table of each element: write/read, background polarity, last op.
    always_comb begin
        op_wr   = 1'b0;
        op_one  = 1'b0;
        op_last = 1'b1;
        unique case (state_q)
            S_M0: op_wr = 1'b1;
            S_M1: begin
                op_wr   = (op_q == 3'd1);
                op_one  = (op_q == 3'd1);
                op_last = (op_q == 3'd1);
            end
            S_M2: begin
                op_wr   = (op_q == 3'd1) || (op_q == 3'd4);
                op_one  = (op_q == 3'd0) || (op_q == 3'd4);
                op_last = (op_q == 3'd4);
            end
            S_M3: begin
                op_wr   = (op_q == 3'd1);
                op_one  = (op_q == 3'd0);
                op_last = (op_q == 3'd1);
            end
            S_M4: begin
                op_wr   = (op_q == 3'd1) || (op_q == 3'd4);
                op_one  = (op_q == 3'd1) || (op_q == 3'd2) || (op_q == 3'd3);
                op_last = (op_q == 3'd4);
            end
            default: op_last = 1'b1;
        endcase
    end

    always_comb begin
        active   = (state_q != S_IDLE) && (state_q != S_DONE);
        elem_end = (state_q == S_M1) ? (addr_q == '0) : (addr_q == A_MAX);
        if (ckbd_q) bg = op_one ? ~CKBD0 : CKBD0;
        else        bg = {DATA_W{op_one}};
    end

    assign addr_out  = addr_q;
    assign dat_out   = active ? bg : '0;
    assign w_en_out  = active && op_wr;
    assign rst_done  = (state_q == S_DONE);
    assign fail      = fail_q;
    assign fail_addr = fail_addr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            addr_q      <= '0;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
`ifdef MARCH_LR_CKBD_EN
            ckbd_q      <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (en_in) begin
                        state_q     <= S_M0;
                        op_q        <= '0;
                        addr_q      <= '0;
                        fail_q      <= 1'b0;
                        fail_addr_q <= '0;
`ifdef MARCH_LR_CKBD_EN
                        ckbd_q      <= 1'b0;
`endif
                    end
                end
                S_DONE: begin
                    if (!en_in) state_q <= S_IDLE;
                end
                default: begin
                    if (!en_in) begin
                        state_q <= S_IDLE;
                        op_q    <= '0;
                        addr_q  <= '0;
                    end else begin
                        if (!op_wr && (dat_in != bg)) begin
                            fail_q <= 1'b1;
                            if (!fail_q) fail_addr_q <= addr_q;
                        end
                        if (!op_last) begin
                            op_q <= op_q + 3'd1;
                        end else begin
                            op_q <= '0;
                            if (!elem_end) begin
                                addr_q <= (state_q == S_M1) ? addr_q - 1'b1
                                                            : addr_q + 1'b1;
                            end else if (state_q == S_M5) begin
                                addr_q <= '0;
`ifdef MARCH_LR_CKBD_EN
                                if (!ckbd_q) begin
                                    ckbd_q  <= 1'b1;
                                    state_q <= S_M0;
                                end else begin
                                    state_q <= S_DONE;
                                end
`else
                                state_q <= S_DONE;
`endif
                            end else begin
                                // M1 is the only descending element.
                                addr_q  <= (state_q == S_M0) ? A_MAX : '0;
                                state_q <= state_t'(state_q + 3'd1);
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_march_lr_bist.sv
// Scoreboard bench for march_lr_bist: SRAM model with stuck-at-0 fault injection,
// expected op stream built from the March LR element table.
module tb_march_lr_bist;

    localparam int AW = 8;
    localparam int DW = 4;
    localparam int N  = 256;
`ifdef MARCH_LR_CKBD_EN
    localparam int PASSES = 2;
`else
    localparam int PASSES = 1;
`endif
    localparam int OPS = 16 * N * PASSES;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en_in = 1'b0;
    logic [DW-1:0] dat_in;
    logic [DW-1:0] dat_out;
    logic [AW-1:0] addr_out;
    logic          w_en_out;
    logic          rst_done;
    logic          fail;
    logic [AW-1:0] fail_addr;

    always #5 clk = ~clk;

    march_lr_bist #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en_in    (en_in),
        .dat_in   (dat_in),
        .dat_out  (dat_out),
        .addr_out (addr_out),
        .w_en_out (w_en_out),
        .rst_done (rst_done),
        .fail     (fail),
        .fail_addr(fail_addr)
    );

    logic [DW-1:0] mem [N];
    int            flt_addr = -1;
    logic [DW-1:0] flt_mask = '0;

    always @(posedge clk) if (w_en_out) mem[addr_out] <= dat_out;
    assign dat_in = mem[addr_out] &
                    ~((int'(addr_out) == flt_addr) ? flt_mask : '0);

    typedef struct {
        int            addr;
        bit            wen;
        logic [DW-1:0] dat;
        bit            fl;
    } op_t;

    op_t sbq[$];
    op_t mon_e;
    int  checks = 0;
    int  failures = 0;
    bit  armed = 0;
    bit  exp_fail;
    int  exp_faddr;

    task automatic check(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (armed && sbq.size() > 0) begin
            mon_e = sbq.pop_front();
            check("addr_out", addr_out, mon_e.addr);
            check("w_en_out", w_en_out, mon_e.wen);
            check("dat_out", dat_out, mon_e.dat);
            check("fail_live", fail, mon_e.fl);
        end
    end

    function automatic logic [DW-1:0] bgval(int pass, bit v);
        logic [DW-1:0] b;
        for (int i = 0; i < DW; i++)
            b[i] = (pass == 0) ? v : (((i % 2) == 0) ^ v);
        return b;
    endfunction

    task automatic build(int faddr, logic [DW-1:0] fmask);
        string         el[6] = '{"w0", "r0w1", "r1w0r0r0w1", "r1w0", "r0w1r1r1w0", "r0"};
        bit            dn[6] = '{0, 1, 0, 0, 0, 0};
        logic [DW-1:0] rm [N];
        logic [DW-1:0] b;
        logic [DW-1:0] rd;
        byte           c;
        byte           v;
        int            a;
        op_t           o;
        for (int i = 0; i < N; i++) rm[i] = '0;
        exp_fail  = 0;
        exp_faddr = 0;
        sbq.delete();
        for (int p = 0; p < PASSES; p++)
            for (int e = 0; e < 6; e++)
                for (int k = 0; k < N; k++) begin
                    a = dn[e] ? N - 1 - k : k;
                    for (int j = 0; j < el[e].len() / 2; j++) begin
                        c = el[e][2*j];
                        v = el[e][2*j+1];
                        b = bgval(p, v == "1");
                        o.addr = a;
                        o.wen  = (c == "w");
                        o.dat  = b;
                        o.fl   = exp_fail;
                        sbq.push_back(o);
                        if (o.wen) rm[a] = b;
                        else begin
                            rd = rm[a] & ((a == faddr) ? ~fmask : '1);
                            if (rd != b) begin
                                if (!exp_fail) exp_faddr = a;
                                exp_fail = 1;
                            end
                        end
                    end
                end
    endtask

    task automatic run(int faddr, logic [DW-1:0] fmask, int abort_at);
        int cyc;
        bit done;
        flt_addr = faddr;
        flt_mask = fmask;
        build(faddr, fmask);
        @(negedge clk);
        en_in = 1'b1;
        armed = 1'b1;
        if (abort_at > 0) begin
            repeat (abort_at) @(posedge clk);
            @(negedge clk);
            en_in = 1'b0;
            armed = 1'b0;
            sbq.delete();
            @(posedge clk);
            #1;
            check("abort_wen", w_en_out, 0);
            check("abort_done", rst_done, 0);
            check("abort_addr", addr_out, 0);
            check("abort_dat", dat_out, 0);
        end else begin
            cyc  = 0;
            done = 0;
            while (cyc < OPS + 20 && !done) begin
                @(posedge clk);
                #1;
                cyc++;
                done = rst_done;
            end
            check("cycles_to_done", cyc, OPS + 1);
            check("queue_drained", sbq.size(), 0);
            check("fail_end", fail, exp_fail);
            check("fail_addr_end", fail_addr, exp_faddr);
            armed = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            check("done_hold", rst_done, 1);
            check("done_wen", w_en_out, 0);
            check("done_addr", addr_out, 0);
            @(negedge clk);
            en_in = 1'b0;
            @(posedge clk);
            #1;
            check("done_clear", rst_done, 0);
            check("fail_hold", fail, exp_fail);
            check("fail_addr_hold", fail_addr, exp_faddr);
        end
    endtask

    initial begin
        int fa;
        for (int i = 0; i < N; i++) mem[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_addr", addr_out, 0);
        check("rst_dat", dat_out, 0);
        check("rst_wen", w_en_out, 0);
        check("rst_done", rst_done, 0);
        check("rst_fail", fail, 0);
        check("rst_fail_addr", fail_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run(-1, '0, 0);
        run(8'h3A, 4'b0100, 0);
        fa = int'($urandom_range(0, N - 1));
        run(fa, 4'(1 << $urandom_range(0, DW - 1)), 0);

        run(-1, '0, 500);
        run(8'h3A, 4'b0100, 2000);
        check("abort_fail_kept", fail, 1);
        check("abort_fail_addr", fail_addr, 8'h3A);
        run(-1, '0, 0);

        // Reset pulse partway through M4 of the first pass.
        flt_addr = 8'h3A;
        flt_mask = 4'b0100;
        build(8'h3A, 4'b0100);
        @(negedge clk);
        en_in = 1'b1;
        armed = 1'b1;
        repeat (10 * N + 100 + $urandom_range(0, 50)) @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        en_in = 1'b0;
        armed = 1'b0;
        sbq.delete();
        #1;
        check("arst_addr", addr_out, 0);
        check("arst_dat", dat_out, 0);
        check("arst_wen", w_en_out, 0);
        check("arst_fail", fail, 0);
        check("arst_fail_addr", fail_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("idle_wen", w_en_out, 0);
            check("idle_done", rst_done, 0);
        end
        run(-1, '0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/march_lr_bist.md
Name: march_lr_bist

Overview:
- MBIST controller that runs the March LR algorithm on a single-port 256x4 SRAM and reports pass/fail.
- Sits between the system enable and the SRAM. It drives address, write data and write enable, and compares read data against the expected values.
- One memory operation per clock. The SRAM write is synchronous on the clock rising edge; the SRAM read is asynchronous (combinational on address).

Parameters:
- ADDR_W, 8, address width; memory depth N = 2^ADDR_W.
- DATA_W, 4, word width; data background "0" = all zeros, "1" = all ones.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en_in  input  1  level enable; rising into RUN starts the test; low aborts it.
- dat_in  input  DATA_W  SRAM read data (asynchronous read of addr_out).
- dat_out  output  DATA_W  SRAM write data.
- addr_out  output  ADDR_W  SRAM address.
- w_en_out  output  1  SRAM write enable; 1 = write dat_out at the next clk edge.
- rst_done  output  1  test complete flag.
- fail  output  1  sticky mismatch flag.
- fail_addr  output  ADDR_W  address of the first mismatch.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; addr_out=0, dat_out=0, w_en_out=0, rst_done=0, fail=0, fail_addr=0.
- March LR sequence, with d = element direction:
  - M0 up (w0)
  - M1 down (r0,w1)
  - M2 up (r1,w0,r0,r0,w1)
  - M3 up (r1,w0)
  - M4 up (r0,w1,r1,r1,w0)
  - M5 up (r0)
- Total 16*N operations; N = 256 gives 4096 cycles.
- States: IDLE, M0, M1, M2, M3, M4, M5, DONE. Internal op index per element, plus address counter.
- Up elements run 0..N-1; the down element (M1) runs N-1..0.
- Within an element, all ops for one address complete before the address steps.
- IDLE -> M0 when en_in=1 at a clk edge. The first operation (w0 @ addr 0) is presented in the following cycle.
- After the last op of an element at its final address, go to the next element. Start at address 0 for up elements, N-1 for M1.
- M5 final read at N-1 -> DONE. rst_done=1 from the next cycle and holds while en_in=1. No restart while en_in stays high.
- DONE -> IDLE when en_in=0. rst_done clears in that transition; fail and fail_addr hold until the next start.
- Start from IDLE clears fail and fail_addr.
- en_in=0 in any M state aborts: next state IDLE, w_en_out=0, rst_done stays 0.
- Write op: w_en_out=1, dat_out = background, addr_out = current address.
- Read op: w_en_out=0, dat_out = expected background. dat_in is compared at the clk edge ending that cycle.
- Mismatch: fail set (sticky). fail_addr is captured only on the first mismatch. The test continues to completion; it does not stop early.
- IDLE/DONE outputs: w_en_out=0, addr_out=0, dat_out=0.
- rst_n low mid-run: immediate return to IDLE with all outputs at reset values.

Optional Feature:
- Macro MARCH_LR_CKBD_EN.
- Defined: after the solid-background pass, run a second full March LR pass with checkerboard backgrounds: "0" = 0101, "1" = 1010 (for DATA_W=4; alternating pattern in general). Total 32*N cycles (8192). rst_done asserts only after the second pass. fail_addr still records the first failure across both passes.
- Undefined: single solid-background pass of 16*N cycles.

Test Plan:
- Fault-free SRAM model, rst_n released, en_in=1 -> w0 at addr 0 one cycle after start; rst_done=1 after exactly 4096 op cycles; fail=0.
- Stuck-at-0 on bit 2 of addr 0x3A -> fail=1 at the first r1 of M2 on addr 0x3A; fail_addr=0x3A; rst_done still asserts after 4096 cycles.
- Monitor addresses in M1 -> addr_out sequence 0xFF,0xFF,0xFE,0xFE,…,0x00,0x00 with w_en_out pattern 0,1 repeating; dat_out 0000 on reads, 1111 on writes.
- en_in dropped at cycle 500 -> next cycle state IDLE, w_en_out=0, rst_done=0. Re-assert en_in -> restart at M0 addr 0 with fail cleared.
- rst_n pulsed low mid-M4 -> outputs go to zero asynchronously; no further writes until en_in is high after reset release.
- MARCH_LR_CKBD_EN defined, fault-free -> 8192 op cycles to rst_done; second-pass writes show dat_out 0101/1010; fail=0.
